dual_rr_arbiter: RTL

Round-robin arbiter sharing two identical resource ports (A and B) among N requesters. Each cycle it scans pending requests in rotating-priority order, picking up to two winners the same way the dual priority decoder does: first found, then second found. It assigns them to whichever ports are free and holds each grant until the resource signals completion. It sits between the requester array and the two shared datapath units, driving their select/enable inputs.

---
 rtl/dual_rr_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dual_rr_arbiter.sv
// dual_rr_arbiter
//
// Shares two identical resource ports (A and B) among N requesters using a
// rotating-priority scan that picks up to two winners per cycle. A granted
// port is held until its resource signals completion through done_a/done_b.
// A port released this cycle can be re-granted on the same edge, so there are
// no idle bubbles between back-to-back jobs.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   req      request vector, bit i = requester i wants a port
//   done_a   port A resource finished, releases port A
//   done_b   port B resource finished, releases port B
//   idx_a    index of the requester holding port A (meaningful while busy_a)
//   busy_a   port A occupied
//   idx_b    index of the requester holding port B (meaningful while busy_b)
//   busy_b   port B occupied
//   gnt      one-hot-per-port grant vector, at most two bits set

module dual_rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done_a,
    input  logic         done_b,
    output logic [W-1:0] idx_a,
    output logic         busy_a,
    output logic [W-1:0] idx_b,
    output logic         busy_b,
    output logic [N-1:0] gnt
);

    localparam logic [W-1:0] LastIdx = W'(N - 1);

    // Step one position down the ring; 0 wraps to N-1 even when N is not a
    // power of two.
    function automatic logic [W-1:0] ring_dec(input logic [W-1:0] v);
        return (v == '0) ? LastIdx : v - 1'b1;
    endfunction

    logic         busy_a_q, busy_a_d;
    logic [W-1:0] idx_a_q,  idx_a_d;
    logic         busy_b_q, busy_b_d;
    logic [W-1:0] idx_b_q,  idx_b_d;
    logic [W-1:0] ptr_q,    ptr_d;
    logic [N-1:0] gnt_q,    gnt_d;

    logic         free_a, free_b;
    logic [N-1:0] cand;
    logic         found_first, found_second;
    logic [W-1:0] first_idx, second_idx;
    logic [W-1:0] scan_pos;

    // done_x only matters while the port is busy.
    assign free_a = ~busy_a_q | done_a;
    assign free_b = ~busy_b_q | done_b;

    // gnt_q is exactly the current holder set, including any holder being
    // released this cycle, so a releasing requester cannot win again at once.
    assign cand = req & ~gnt_q;

    // Rotating-priority scan: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
    always_comb begin
        found_first  = 1'b0;
        found_second = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        scan_pos     = ptr_q;
        for (int k = 0; k < int'(N); k++) begin
            if (cand[scan_pos]) begin
                if (!found_first) begin
                    found_first = 1'b1;
                    first_idx   = scan_pos;
                end else if (!found_second) begin
                    found_second = 1'b1;
                    second_idx   = scan_pos;
                end
            end
            scan_pos = ring_dec(scan_pos);
        end
    end

    // Port assignment and pointer update. A free port with no winner clears
    // its busy flag but keeps its last index.
    always_comb begin
        busy_a_d = busy_a_q;
        idx_a_d  = idx_a_q;
        busy_b_d = busy_b_q;
        idx_b_d  = idx_b_q;
        ptr_d    = ptr_q;

        if (free_a && free_b) begin
            busy_a_d = found_first;
            busy_b_d = found_second;
            if (found_first) begin
                idx_a_d = first_idx;
            end
            if (found_second) begin
                idx_b_d = second_idx;
            end
            // The lowest-priority winner is the last one found in scan order.
            if (found_second) begin
                ptr_d = ring_dec(second_idx);
            end else if (found_first) begin
                ptr_d = ring_dec(first_idx);
            end
        end else if (free_a) begin
            busy_a_d = found_first;
            if (found_first) begin
                idx_a_d = first_idx;
                ptr_d   = ring_dec(first_idx);
            end
        end else if (free_b) begin
            busy_b_d = found_first;
            if (found_first) begin
                idx_b_d = first_idx;
                ptr_d   = ring_dec(first_idx);
            end
        end
    end

    // Registered grant vector derived from the next port state.
    always_comb begin
        gnt_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            gnt_d[i] = (busy_a_d && (idx_a_d == W'(i))) || (busy_b_d && (idx_b_d == W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_a_q <= 1'b0;
            idx_a_q  <= '0;
            busy_b_q <= 1'b0;
            idx_b_q  <= '0;
            ptr_q    <= LastIdx;
            gnt_q    <= '0;
        end else begin
            busy_a_q <= busy_a_d;
            idx_a_q  <= idx_a_d;
            busy_b_q <= busy_b_d;
            idx_b_q  <= idx_b_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
        end
    end

    assign busy_a = busy_a_q;
    assign idx_a  = idx_a_q;
    assign busy_b = busy_b_q;
    assign idx_b  = idx_b_q;
    assign gnt    = gnt_q;

endmodule
